// File: rtl/line_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// line_buffer_ctrl
// Sequencing controller for a three-RAM video line buffer. It picks which RAM
// the current line is written into, rotates that choice at every line commit,
// drives the read-mux selects for the two stored lines, tracks the row/column
// position and the buffer fill level, and flags malformed lines.
//
// Ports:
//   clk         pixel clock
//   rstn        asynchronous active-low reset
//   hsync       horizontal sync (unused; line ends come from de falling)
//   vsync       vertical sync, active high; restarts the frame while high
//   de          data enable, one pixel per cycle while high
//   wen         one-hot RAM write enable (bit0 = RAM0), gated with de
//   rd_sel1     RAM index holding the oldest stored line (y-2)
//   rd_sel2     RAM index holding the newest stored line (y-1)
//   col         index of the pixel presented this cycle (saturates at H_ACT)
//   row         index of the line currently being written
//   lines_valid completed lines held in the buffer, saturating at 2
//   win_valid   all three window rows are valid for this pixel
//   last_row    current line is the last line of the frame
//   frame_err   sticky flag for short or overlong lines
// -----------------------------------------------------------------------------
module line_buffer_ctrl #(
    parameter int H_ACT = 1280,
    parameter int V_ACT = 720,
    localparam int CW = $clog2(H_ACT) + 1,
    localparam int RW = $clog2(V_ACT)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          de,
    output logic [2:0]    wen,
    output logic [1:0]    rd_sel1,
    output logic [1:0]    rd_sel2,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic [1:0]    lines_valid,
    output logic          win_valid,
    output logic          last_row,
    output logic          frame_err
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] COL_MAX  = CW'(H_ACT);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_ACT - 1);

    // Next write index in the 0->1->2->0 rotation; the illegal code 3 maps to 0.
    function automatic logic [1:0] wid_inc(input logic [1:0] w);
        logic [1:0] r;
        case (w)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    wid_q, wid_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    lv_q, lv_d;
    logic          err_q, err_d;
    logic          de_q;
    logic          vsync_q;

    logic          commit_s;
    logic          vsync_fall_s;
    logic          active_s;
    logic          col_ok_s;
    logic [2:0]    wid_oh_s;

    // Edge detects, write gating and read-mux selects decoded from wid.
    always_comb begin
        commit_s     = de_q & ~de;
        vsync_fall_s = vsync_q & ~vsync;
        active_s     = (state_q == ST_FILL) || (state_q == ST_RUN);
        col_ok_s     = (col_q < COL_MAX);
        wid_oh_s     = 3'b000;
        rd_sel1      = 2'd1;
        rd_sel2      = 2'd2;
        case (wid_q)
            2'd0: begin
                wid_oh_s = 3'b001;
                rd_sel1  = 2'd1;
                rd_sel2  = 2'd2;
            end
            2'd1: begin
                wid_oh_s = 3'b010;
                rd_sel1  = 2'd2;
                rd_sel2  = 2'd0;
            end
            2'd2: begin
                wid_oh_s = 3'b100;
                rd_sel1  = 2'd0;
                rd_sel2  = 2'd1;
            end
            default: begin
                // Unreachable index: no write, selects as for wid=0.
                wid_oh_s = 3'b000;
                rd_sel1  = 2'd1;
                rd_sel2  = 2'd2;
            end
        endcase
        if (de && active_s && col_ok_s) begin
            wen = wid_oh_s;
        end else begin
            wen = 3'b000;
        end
        win_valid   = de && (state_q == ST_RUN);
        last_row    = active_s && (row_q == ROW_LAST);
        col         = col_q;
        row         = row_q;
        lines_valid = lv_q;
        frame_err   = err_q;
    end

    // Next-state logic: vsync level restarts the frame and outranks a commit.
    always_comb begin
        state_d = state_q;
        wid_d   = wid_q;
        col_d   = col_q;
        row_d   = row_q;
        lv_d    = lv_q;
        if (vsync) begin
            state_d = ST_WAIT;
            wid_d   = 2'd0;
            row_d   = {RW{1'b0}};
            col_d   = {CW{1'b0}};
            lv_d    = 2'd0;
        end else begin
            if (commit_s) begin
                col_d = {CW{1'b0}};
            end else if (de && col_ok_s) begin
                col_d = col_q + CW'(1);
            end else begin
                col_d = col_q;
            end
            if (wid_q == 2'd3) begin
                wid_d = 2'd0;
            end else begin
                wid_d = wid_q;
            end
            case (state_q)
                ST_WAIT: begin
                    if (vsync_fall_s) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_FILL: begin
                    if (commit_s) begin
                        wid_d = wid_inc(wid_q);
                        row_d = row_q + RW'(1);
                        lv_d  = (lv_q == 2'd2) ? 2'd2 : lv_q + 2'd1;
                        if (lv_q >= 2'd1) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_RUN: begin
                    if (commit_s) begin
                        wid_d = wid_inc(wid_q);
                        // The last line holds row rather than wrapping; row
                        // is not meaningful once the frame is done.
                        if (row_q == ROW_LAST) begin
                            state_d = ST_DONE;
                            row_d   = row_q;
                        end else begin
                            state_d = ST_RUN;
                            row_d   = row_q + RW'(1);
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_WAIT;
                end
            endcase
        end
        // Overlong: a pixel arrives after col saturated. Short: a real commit
        // (not pre-empted by vsync) before H_ACT pixels were seen.
        err_d = err_q
              | (de && (col_q == COL_MAX))
              | (commit_s && !vsync && active_s && (col_q != COL_MAX));
    end

    // State and position registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_WAIT;
            wid_q   <= 2'd0;
            col_q   <= {CW{1'b0}};
            row_q   <= {RW{1'b0}};
            lv_q    <= 2'd0;
            err_q   <= 1'b0;
            de_q    <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wid_q   <= wid_d;
            col_q   <= col_d;
            row_q   <= row_d;
            lv_q    <= lv_d;
            err_q   <= err_d;
            de_q    <= de;
            vsync_q <= vsync;
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_buffer_ctrl
// Directed bench for line_buffer_ctrl with H_ACT=8, V_ACT=4. Inputs change
// 1 ns after the rising edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_line_buffer_ctrl;

    localparam int H = 8;
    localparam int V = 4;

    logic       clk;
    logic       rstn;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [2:0] wen;
    logic [1:0] rd_sel1;
    logic [1:0] rd_sel2;
    logic [3:0] col;
    logic [1:0] row;
    logic [1:0] lines_valid;
    logic       win_valid;
    logic       last_row;
    logic       frame_err;

    int checks;
    int failures;

    line_buffer_ctrl #(.H_ACT(H), .V_ACT(V)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .wen        (wen),
        .rd_sel1    (rd_sel1),
        .rd_sel2    (rd_sel2),
        .col        (col),
        .row        (row),
        .lines_valid(lines_valid),
        .win_valid  (win_valid),
        .last_row   (last_row),
        .frame_err  (frame_err)
    );

    // Pixel clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock step: drive inputs after the rising edge, return at falling edge.
    task automatic drive(input logic v, input logic d);
        @(posedge clk);
        #1;
        vsync = v;
        de    = d;
        @(negedge clk);
    endtask

    task automatic vsync_pulse();
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    // n pixels, then the commit cycle and one idle cycle. erow < 0 skips row.
    task automatic send_line(input int n, input logic [2:0] ew, input logic [1:0] elv,
                             input logic ewin, input int erow, input logic [1:0] e1,
                             input logic [1:0] e2, input logic elast);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1);
            check("wen", wen, (i < H) ? ew : 3'b000);
            check("col", col, (i < H) ? i : H);
            if (i == 0) begin
                check("lines_valid", lines_valid, elv);
                check("win_valid", win_valid, ewin);
                check("rd_sel1", rd_sel1, e1);
                check("rd_sel2", rd_sel2, e2);
                check("last_row", last_row, elast);
                if (erow >= 0) begin
                    check("row", row, erow);
                end
            end
        end
        drive(1'b0, 1'b0);
        check("wen_commit", wen, 3'b000);
        drive(1'b0, 1'b0);
        check("col_after_commit", col, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        hsync    = 1'b0;
        vsync    = 1'b0;
        de       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wen", wen, 3'b000);
        check("rst_rd_sel1", rd_sel1, 2'd1);
        check("rst_rd_sel2", rd_sel2, 2'd2);
        check("rst_lines_valid", lines_valid, 2'd0);
        check("rst_win_valid", win_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_col", col, 0);
        check("rst_row", row, 0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // WAIT blocks writes before the first vsync.
        drive(1'b0, 1'b1);
        check("wait_wen", wen, 3'b000);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);

        // Frame A: four good lines, then a fifth line in DONE.
        vsync_pulse();
        send_line(8, 3'b001, 2'd0, 1'b0, 0, 2'd1, 2'd2, 1'b0);
        send_line(8, 3'b010, 2'd1, 1'b0, 1, 2'd2, 2'd0, 1'b0);
        send_line(8, 3'b100, 2'd2, 1'b1, 2, 2'd0, 2'd1, 1'b0);
        send_line(8, 3'b001, 2'd2, 1'b1, 3, 2'd1, 2'd2, 1'b1);
        send_line(8, 3'b000, 2'd2, 1'b0, -1, 2'd2, 2'd0, 1'b0);
        check("frameA_err", frame_err, 1'b0);

        // Frame B: short third line.
        vsync_pulse();
        check("vs_lines_valid", lines_valid, 2'd0);
        check("vs_rd_sel1", rd_sel1, 2'd1);
        send_line(8, 3'b001, 2'd0, 1'b0, 0, 2'd1, 2'd2, 1'b0);
        send_line(8, 3'b010, 2'd1, 1'b0, 1, 2'd2, 2'd0, 1'b0);
        check("pre_short_err", frame_err, 1'b0);
        send_line(5, 3'b100, 2'd2, 1'b1, 2, 2'd0, 2'd1, 1'b0);
        check("short_err", frame_err, 1'b1);
        check("short_rd_sel1", rd_sel1, 2'd1);
        check("short_rd_sel2", rd_sel2, 2'd2);
        send_line(8, 3'b001, 2'd2, 1'b1, 3, 2'd1, 2'd2, 1'b1);
        vsync_pulse();
        check("err_sticky_vsync", frame_err, 1'b1);
        check("vs_row", row, 0);

        // vsync mid-line in RUN with de still high.
        send_line(8, 3'b001, 2'd0, 1'b0, 0, 2'd1, 2'd2, 1'b0);
        send_line(8, 3'b010, 2'd1, 1'b0, 1, 2'd2, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1);
            check("mid_wen", wen, 3'b100);
        end
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        check("midvs_wen", wen, 3'b000);
        check("midvs_win_valid", win_valid, 1'b0);
        check("midvs_lines_valid", lines_valid, 2'd0);
        check("midvs_rd_sel1", rd_sel1, 2'd1);
        check("midvs_rd_sel2", rd_sel2, 2'd2);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);

        // vsync coincident with the de falling edge: no rotation.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1);
        end
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        check("vscommit_rd_sel1", rd_sel1, 2'd1);
        check("vscommit_lines_valid", lines_valid, 2'd0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        send_line(8, 3'b001, 2'd0, 1'b0, 0, 2'd1, 2'd2, 1'b0);

        // Reset clears the sticky error; then an overlong line.
        @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        check("rst2_frame_err", frame_err, 1'b0);
        check("rst2_rd_sel1", rd_sel1, 2'd1);
        @(posedge clk);
        #1 rstn = 1'b1;
        vsync_pulse();
        send_line(10, 3'b001, 2'd0, 1'b0, 0, 2'd1, 2'd2, 1'b0);
        check("long_err", frame_err, 1'b1);
        check("long_rd_sel1", rd_sel1, 2'd2);
        check("long_lines_valid", lines_valid, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
